// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core's DM_* port and a debug/DMA requester.
// The core has priority; a starvation counter forces a debug slot, and a lock mode grants burst ownership.
module dmem_arbiter #(
    parameter int N        = 64,
    parameter int AW       = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [N-1:0]  cpu_wdata,
    input  logic          cpu_memWrite,
    input  logic          cpu_memRead,
    output logic [N-1:0]  cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [N-1:0]  dbg_wdata,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic [N-1:0]  dbg_rdata,
    output logic          dbg_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [N-1:0]  mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {CPU_OWN, DBG_SLOT, DBG_LOCK} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          cpu_active;
    logic          dbg_blocked;

    assign cpu_active  = cpu_memRead | cpu_memWrite;
    assign cpu_rdata   = mem_rdata;
    assign dbg_blocked = dbg_req & cpu_active;

    // Outside CPU_OWN the core is frozen, so any pending debug request owns the port.
    always_comb begin
        cpu_stall = (state != CPU_OWN);
        dbg_gnt   = dbg_req & (cpu_stall | ~cpu_active);
        if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
            mem_re    = ~dbg_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_memWrite & ~cpu_stall;
            mem_re    = cpu_memRead & ~cpu_stall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CPU_OWN;
            wait_cnt   <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt & ~dbg_we)
                dbg_rdata <= mem_rdata;

            case (state)
                CPU_OWN: begin
                    // Counter restarts when the forced slot is taken so it never reaches MAX_WAIT.
                    if (dbg_blocked && wait_cnt != WAIT_LAST)
                        wait_cnt <= wait_cnt + 1'b1;
                    else
                        wait_cnt <= '0;
                    if (dbg_lock)
                        state <= DBG_LOCK;
                    else if (dbg_blocked && wait_cnt == WAIT_LAST)
                        state <= DBG_SLOT;
                end
                DBG_SLOT, DBG_LOCK: begin
                    wait_cnt <= '0;
                    state    <= dbg_lock ? DBG_LOCK : CPU_OWN;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= CPU_OWN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read memory model behind the mem_* port.
module tb_dmem_arbiter;

    localparam int N = 64;
    localparam int AW = 6;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [N-1:0]  cpu_wdata;
    logic          cpu_memWrite;
    logic          cpu_memRead;
    logic [N-1:0]  cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_wdata;
    logic          dbg_lock;
    logic          dbg_gnt;
    logic [N-1:0]  dbg_rdata;
    logic          dbg_rvalid;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [N-1:0]  mem_rdata;

    logic [N-1:0]  mem [64];

    int nvec = 0;
    int nerr = 0;

    dmem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memWrite(cpu_memWrite), .cpu_memRead(cpu_memRead),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Contents after the forced-slot write of 64'h1234 to word 3.
    function automatic logic [N-1:0] exp_word(input int i);
        if (i == 3) return 64'h1234;
        if (i == 5) return 64'hDEAD_BEEF;
        return 64'hA000 + 64'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hA000 + 64'(i);
        mem[5] = 64'hDEAD_BEEF;
        reset = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_memWrite = 1'b0; cpu_memRead = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
        tick();
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_gnt", 64'(dbg_gnt), 64'd0);
        check("rst_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rst_rdata", dbg_rdata, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Idle core: same-cycle debug read of word 5.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
        #1;
        check("idle_gnt", 64'(dbg_gnt), 64'd1);
        check("idle_re", 64'(mem_re), 64'd1);
        check("idle_we", 64'(mem_we), 64'd0);
        check("idle_addr", 64'(mem_addr), 64'd5);
        check("idle_stall", 64'(cpu_stall), 64'd0);
        tick();
        dbg_req = 1'b0;
        check("idle_rvalid", 64'(dbg_rvalid), 64'd1);
        check("idle_rdata", dbg_rdata, 64'hDEAD_BEEF);
        tick();
        check("idle_rvalid_off", 64'(dbg_rvalid), 64'd0);
        check("idle_rdata_hold", dbg_rdata, 64'hDEAD_BEEF);

        // Core reads every cycle; debug write is forced in after MAX_WAIT blocked cycles.
        cpu_memRead = 1'b1; cpu_addr = 6'd10;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd3; dbg_wdata = 64'h1234;
        for (int c = 0; c < MAX_WAIT; c++) begin
            #1;
            check("starve_gnt", 64'(dbg_gnt), 64'd0);
            check("starve_stall", 64'(cpu_stall), 64'd0);
            check("starve_addr", 64'(mem_addr), 64'd10);
            check("starve_re", 64'(mem_re), 64'd1);
            tick();
        end
        #1;
        check("slot_stall", 64'(cpu_stall), 64'd1);
        check("slot_gnt", 64'(dbg_gnt), 64'd1);
        check("slot_we", 64'(mem_we), 64'd1);
        check("slot_re", 64'(mem_re), 64'd0);
        check("slot_addr", 64'(mem_addr), 64'd3);
        tick();
        dbg_req = 1'b0;
        #1;
        check("slot_mem3", mem[3], 64'h1234);
        check("slot_no_rvalid", 64'(dbg_rvalid), 64'd0);
        check("resume_stall", 64'(cpu_stall), 64'd0);
        check("resume_re", 64'(mem_re), 64'd1);
        check("resume_addr", 64'(mem_addr), 64'd10);
        check("resume_rdata", cpu_rdata, 64'hA00A);
        tick();

        // Blocked request dropped one cycle short of the forced slot must restart the count.
        dbg_we = 1'b0; dbg_addr = 6'd7;
        for (int c = 0; c < 2 * MAX_WAIT - 1; c++) begin
            dbg_req = (c != MAX_WAIT - 1);
            #1;
            check("pulse_stall", 64'(cpu_stall), 64'd0);
            check("pulse_gnt", 64'(dbg_gnt), 64'd0);
            tick();
        end
        dbg_req = 1'b0;
        tick();

        // Lock burst: walk every word while the core keeps requesting.
        cpu_memRead = 1'b1; cpu_addr = 6'd20;
        dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd0;
        #1;
        check("lock_enter_gnt", 64'(dbg_gnt), 64'd0);
        check("lock_enter_stall", 64'(cpu_stall), 64'd0);
        tick();
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                check("lock_rvalid", 64'(dbg_rvalid), 64'd1);
                check("lock_rdata", dbg_rdata, exp_word(i - 1));
            end
            dbg_addr = 6'(i);
            #1;
            check("lock_stall", 64'(cpu_stall), 64'd1);
            check("lock_gnt", 64'(dbg_gnt), 64'd1);
            check("lock_addr", 64'(mem_addr), 64'(i));
            tick();
        end
        check("lock_rvalid_last", 64'(dbg_rvalid), 64'd1);
        check("lock_rdata_last", dbg_rdata, exp_word(63));
        dbg_lock = 1'b0; dbg_req = 1'b0;
        #1;
        check("unlock_stall", 64'(cpu_stall), 64'd1);
        check("unlock_gnt", 64'(dbg_gnt), 64'd0);
        tick();
        check("unlock_rvalid_off", 64'(dbg_rvalid), 64'd0);
        check("unlock_resume_stall", 64'(cpu_stall), 64'd0);
        check("unlock_resume_re", 64'(mem_re), 64'd1);
        check("unlock_resume_addr", 64'(mem_addr), 64'd20);

        // Core write collides with a fresh debug request: the core wins.
        cpu_memRead = 1'b0; cpu_memWrite = 1'b1; cpu_addr = 6'd12; cpu_wdata = 64'h55;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd9;
        #1;
        check("coll_gnt", 64'(dbg_gnt), 64'd0);
        check("coll_we", 64'(mem_we), 64'd1);
        check("coll_addr", 64'(mem_addr), 64'd12);
        check("coll_wdata", mem_wdata, 64'h55);
        tick();
        check("coll_mem12", mem[12], 64'h55);
        cpu_memWrite = 1'b0;
        #1;
        check("coll_late_gnt", 64'(dbg_gnt), 64'd1);
        check("coll_late_addr", 64'(mem_addr), 64'd9);
        tick();
        dbg_req = 1'b0;
        check("coll_rvalid", 64'(dbg_rvalid), 64'd1);
        check("coll_rdata", dbg_rdata, 64'hA009);
        tick();

        // Reset while a forced-slot read is being granted.
        cpu_memRead = 1'b1; cpu_addr = 6'd10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
        for (int c = 0; c < MAX_WAIT; c++) tick();
        #1;
        check("rslot_stall", 64'(cpu_stall), 64'd1);
        check("rslot_gnt", 64'(dbg_gnt), 64'd1);
        reset = 1'b1;
        #1;
        check("rslot_rst_stall", 64'(cpu_stall), 64'd0);
        check("rslot_rst_gnt", 64'(dbg_gnt), 64'd0);
        check("rslot_rst_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rslot_rst_rdata", dbg_rdata, 64'd0);
        dbg_req = 1'b0; cpu_memRead = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rslot_post_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rslot_post_rdata", dbg_rdata, 64'd0);
        check("rslot_post_stall", 64'(cpu_stall), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
